// File: rtl/tnn_feature_quantizer.sv
// rtl/tnn_feature_quantizer.sv - 2-bit feature quantizer and 7-feature frame assembler for the TNN classifier
module tnn_feature_quantizer #(
  parameter int N_FEAT  = 7,
  parameter int IN_W    = 8,
  parameter int T0_INIT = 64,
  parameter int T1_INIT = 128,
  parameter int T2_INIT = 192
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_last,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_feat,
  input  logic [1:0]      cfg_sel,
  input  logic [IN_W-1:0] cfg_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [1:0]      input_a,
  output logic [1:0]      input_b,
  output logic [1:0]      input_c,
  output logic [1:0]      input_d,
  output logic [1:0]      input_e,
  output logic [1:0]      input_f,
  output logic [1:0]      input_g,
  output logic            frame_err,
  output logic [15:0]     frame_cnt
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [IN_W-1:0] r_thr0 [0:N_FEAT-1];
  logic [IN_W-1:0] r_thr1 [0:N_FEAT-1];
  logic [IN_W-1:0] r_thr2 [0:N_FEAT-1];
  logic [1:0]      r_stage [0:N_FEAT-1];
  logic [1:0]      r_out [0:N_FEAT-1];
  logic            r_m_valid;
  logic            r_frame_err;
  logic [15:0]     r_frame_cnt;

  logic       w_accept;
  logic       w_c0;
  logic       w_c1;
  logic       w_c2;
  logic [1:0] w_q;
  logic       w_last_idx;
  logic       w_cfg_ok;

  assign s_ready    = (r_state == COLLECT);
  assign w_accept   = s_valid && s_ready;
  assign w_c0       = (s_data >= r_thr0[r_idx]);
  assign w_c1       = (s_data >= r_thr1[r_idx]);
  assign w_c2       = (s_data >= r_thr2[r_idx]);
  assign w_q        = {1'b0, w_c0} + {1'b0, w_c1} + {1'b0, w_c2};
  assign w_last_idx = (r_idx == 3'(N_FEAT - 1));
  assign w_cfg_ok   = cfg_we && (cfg_feat < 3'(N_FEAT)) && (cfg_sel != 2'd3);

  // Threshold table; an accept in the same cycle still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) begin
        r_thr0[i] <= IN_W'(T0_INIT);
        r_thr1[i] <= IN_W'(T1_INIT);
        r_thr2[i] <= IN_W'(T2_INIT);
      end
    end else if (w_cfg_ok) begin
      case (cfg_sel)
        2'd0:    r_thr0[cfg_feat] <= cfg_data;
        2'd1:    r_thr1[cfg_feat] <= cfg_data;
        default: r_thr2[cfg_feat] <= cfg_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_idx       <= 3'd0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= 16'd0;
      for (int i = 0; i < N_FEAT; i++) begin
        r_stage[i] <= 2'd0;
        r_out[i]   <= 2'd0;
      end
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            if (!w_last_idx && !s_last) begin
              r_stage[r_idx] <= w_q;
              r_idx          <= r_idx + 3'd1;
            end else if (w_last_idx && s_last) begin
              // The closing sample bypasses staging so all slots load together.
              for (int i = 0; i < N_FEAT; i++) begin
                r_out[i] <= (3'(i) == r_idx) ? w_q : r_stage[i];
              end
              r_idx     <= 3'd0;
              r_state   <= HOLD;
              r_m_valid <= 1'b1;
            end else begin
              r_idx       <= 3'd0;
              r_frame_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_m_valid && m_ready) begin
            r_m_valid   <= 1'b0;
            r_state     <= COLLECT;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
  assign input_a   = r_out[0];
  assign input_b   = r_out[1];
  assign input_c   = r_out[2];
  assign input_d   = r_out[3];
  assign input_e   = r_out[4];
  assign input_f   = r_out[5];
  assign input_g   = r_out[6];

endmodule

// File: doc/tnn_feature_quantizer.md
Name: tnn_feature_quantizer

Overview:
- Upstream front-end for the 7-input, 2-bit-per-input breast-cancer TNN classifier cores.
- Accepts raw 8-bit feature samples one per beat over a valid/ready stream.
- Quantizes each sample to 2 bits against three programmable per-feature thresholds and assembles a 7-feature frame.
- Presents the frame as input_a..input_g, holding it stable under a valid/ready handshake until the classifier stage consumes it.

Parameters:
- N_FEAT, 7, features per frame; fixed at 7 in this release.
- IN_W, 8, raw feature width.
- T0_INIT, 64, reset value of threshold 0 for every feature.
- T1_INIT, 128, reset value of threshold 1 for every feature.
- T2_INIT, 192, reset value of threshold 2 for every feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  raw sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  IN_W  raw feature value.
- s_last  in  1  marks the 7th sample of a frame.
- cfg_we  in  1  threshold write strobe.
- cfg_feat  in  3  feature index 0..6; writes with 7 are ignored.
- cfg_sel  in  2  threshold index 0..2; writes with 3 are ignored.
- cfg_data  in  IN_W  threshold value.
- m_valid  out  1  frame valid.
- m_ready  in  1  downstream accepts the frame.
- input_a, input_b, input_c, input_d, input_e, input_f, input_g  out  2 each  quantized features 0..6, in arrival order.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- frame_cnt  out  16  count of frames handed off downstream; wraps at 65535 -> 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT, idx=0.
  - m_valid=0, frame_err=0, frame_cnt=0, all input_* = 0.
  - All thresholds return to T0_INIT/T1_INIT/T2_INIT.
- s_ready is combinational: 1 iff state==COLLECT. A beat is accepted when s_valid&&s_ready.
- Quantization of each accepted beat: q = (s_data>=T0[idx]) + (s_data>=T1[idx]) + (s_data>=T2[idx]).
  - Result is 0..3. Comparisons are unsigned.
  - Threshold ordering is not enforced; the sum rule applies as written.
- Each accepted q is registered into the feature slot for idx.
- COLLECT state:
  - Accept with idx<6 and s_last=0: store q, idx<=idx+1.
  - Accept with idx==6 and s_last=1: store q, idx<=0, state<=HOLD, m_valid<=1 on the next edge.
  - Alignment error (accept with idx<6 and s_last=1, or idx==6 and s_last=0):
    - Sample is dropped and frame_err pulses for exactly 1 cycle.
    - idx<=0; stays in COLLECT.
    - input_* keep their previously emitted values.
- HOLD state:
  - m_valid=1 and input_* stable; s_ready=0.
  - On m_valid&&m_ready: m_valid<=0, state<=COLLECT, frame_cnt<=frame_cnt+1.
- Latency: last beat accepted at edge t -> m_valid=1 after edge t. Minimum frame period is 8 cycles (7 beats + 1 handoff cycle).
- Output register update:
  - input_* update only when a complete good frame closes.
  - Slots are staged internally during COLLECT, so outputs do not ripple mid-frame.
  - The full 14-bit vector is loaded on the closing edge.
- Config writes:
  - Take effect on the next edge and may occur in any state.
  - A write and an accept to the same feature in the same cycle: the accept uses the old threshold.
- Reset mid-frame or mid-HOLD: partial frame is discarded and m_valid drops immediately (asynchronous).
- m_ready while m_valid=0 is ignored.

Test Plan:
- Default thresholds, samples 0,63,64,127,128,191,255 with last on the 7th, m_ready=1 -> frame a..g = 0,0,1,1,2,2,3; m_valid high 1 cycle after the 7th accept; frame_cnt=1.
- m_ready=0 for 5 cycles after a frame -> m_valid and input_* stay constant; s_ready=0; s_valid beats are not accepted; the frame is released on the m_ready=1 cycle.
- s_last asserted on the 4th beat -> frame_err pulses 1 cycle, m_valid stays 0; a following correct 7-beat frame of all 200 -> all outputs = 3.
- cfg write feature 2, sel 0, data 10, then a frame of all 20 -> input_c=1, all other outputs = 0.
- 7 beats with no s_last on the 7th -> frame_err pulses, no m_valid; frame_cnt unchanged.
- rst_n low during HOLD -> m_valid=0 and frame_cnt=0 immediately; thresholds are back to 64/128/192, verified by a repeat of the first scenario.
